antisat_seq_lock: RTL and testbench

- Parametrised, sequential successor to the flat 20-input Anti-SAT lock.
- Holds a 2*WIDTH-bit key, loaded serially over a valid/ready handshake.
- Evaluates the Anti-SAT g / gbar pair over WIDTH protected inputs and XORs the result into one protected internal net (prot_in -> prot_out).
- Adds a selectable gate mode, a configurable pipeline depth, and corrupt-until-loaded behaviour.

---
 rtl/antisat_seq_lock_pkg.sv | 16 +
 rtl/antisat_seq_lock_if.sv | 20 ++
 rtl/antisat_seq_lock_core.sv | 34 +++
 rtl/antisat_seq_lock.sv | 105 ++++++++++
 tb/tb_antisat_seq_lock.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/antisat_seq_lock_pkg.sv
// Shared types and helpers for the sequential Anti-SAT lock.
package antisat_pkg;

    localparam int ANTISAT_MODE_AND = 0;
    localparam int ANTISAT_MODE_NOR = 1;

    typedef enum logic {
        ST_LOAD,
        ST_ARMED
    } state_t;

    function automatic int key_cnt_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/antisat_seq_lock_if.sv
// Serial key-loading handshake between a key source (master) and the lock (slave).
interface antisat_seq_lock_if;

    logic key_bit;
    logic key_valid;
    logic key_ready;
    logic key_clear;
    logic key_loaded;

    modport master (
        output key_bit, key_valid, key_clear,
        input  key_ready, key_loaded
    );

    modport slave (
        input  key_bit, key_valid, key_clear,
        output key_ready, key_loaded
    );

endinterface

// File: rtl/antisat_seq_lock_core.sv
// Combinational Anti-SAT g/gbar pair; y is high only for the single x that defeats a wrong key.
module antisat_core
    import antisat_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int MODE  = ANTISAT_MODE_AND
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] kg,
    input  logic [WIDTH-1:0] kgb,
    output logic             y
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             g;
    logic             gbar;

    assign a = x ^ kg;
    assign b = x ^ kgb;

    generate
        if (MODE == ANTISAT_MODE_NOR) begin : g_nor
            assign g    = ~|a;
            assign gbar = |b;
        end else begin : g_and
            assign g    = &a;
            assign gbar = ~&b;
        end
    endgenerate

    assign y = g & gbar;

endmodule

// File: rtl/antisat_seq_lock.sv
// Sequential Anti-SAT lock: serial key load, corrupt-until-armed gating, PIPE-deep output pipeline.
module antisat_seq_lock
    import antisat_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int MODE  = ANTISAT_MODE_AND,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x_in,
    input  logic             prot_in,
    output logic             prot_out,
    output logic             y_out,
    antisat_seq_lock_if.slave key_if
);

    localparam int KW = 2 * WIDTH;
    localparam int CW = key_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_BEAT = CW'(KW - 1);

    state_t          state;
    state_t          state_next;
    logic [KW-1:0]   key_reg;
    logic [CW-1:0]   beat_cnt;
    logic            beat_ok;
    logic            y_core;
    logic            y_comb;
    logic [PIPE-1:0] prot_pipe;
    logic [PIPE-1:0] y_pipe;

    assign beat_ok = (state == ST_LOAD) && key_if.key_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: begin
                if (key_if.key_clear) begin
                    state_next = ST_LOAD;
                end else if (beat_ok && (beat_cnt == LAST_BEAT)) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (key_if.key_clear) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // A clear that coincides with a beat discards the beat.
    always_ff @(posedge clk) begin
        if (!rst_n || key_if.key_clear) begin
            key_reg  <= '0;
            beat_cnt <= '0;
        end else if (beat_ok) begin
            key_reg[beat_cnt] <= key_if.key_bit;
            beat_cnt          <= beat_cnt + CW'(1);
        end
    end

    assign key_if.key_ready  = (state == ST_LOAD) && rst_n;
    assign key_if.key_loaded = (state == ST_ARMED) && rst_n;

    antisat_core #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_core (
        .x   (x_in),
        .kg  (key_reg[WIDTH-1:0]),
        .kgb (key_reg[KW-1:WIDTH]),
        .y   (y_core)
    );

    assign y_comb = (state == ST_ARMED) ? y_core : 1'b1;

    // Free-running shift register; in-flight values are never altered by clear or arming.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prot_pipe <= '0;
            y_pipe    <= '0;
        end else begin
            prot_pipe[0] <= prot_in ^ y_comb;
            y_pipe[0]    <= y_comb;
            for (int i = 1; i < PIPE; i++) begin
                prot_pipe[i] <= prot_pipe[i-1];
                y_pipe[i]    <= y_pipe[i-1];
            end
        end
    end

    assign prot_out = prot_pipe[PIPE-1];
    assign y_out    = y_pipe[PIPE-1];

endmodule

// File: tb/tb_antisat_seq_lock.sv
// Scoreboard bench: two locks (MODE 0/PIPE 1 and MODE 1/PIPE 3) share one directed key/data stream.
module tb_antisat_seq_lock;

    typedef struct {
        int   due;
        logic prot;
        logic y;
    } exp_t;

    typedef struct {
        int   due;
        logic ready;
        logic loaded;
    } st_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] x_in;
    logic       prot_in;
    logic       prot_a, y_a, prot_b, y_b;

    antisat_seq_lock_if kif_a ();
    antisat_seq_lock_if kif_b ();

    antisat_seq_lock #(.WIDTH(4), .MODE(0), .PIPE(1)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .x_in     (x_in),
        .prot_in  (prot_in),
        .prot_out (prot_a),
        .y_out    (y_a),
        .key_if   (kif_a)
    );

    antisat_seq_lock #(.WIDTH(4), .MODE(1), .PIPE(3)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .x_in     (x_in),
        .prot_in  (prot_in),
        .prot_out (prot_b),
        .y_out    (y_b),
        .key_if   (kif_b)
    );

    always #5 clk = ~clk;

    exp_t q_a[$];
    exp_t q_b[$];
    st_t  q_s[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_key    = '0;
    int         m_cnt    = 0;
    logic       m_loaded = 1'b0;

    // Y is forced high until armed; otherwise high only for the one x that defeats a wrong key.
    function automatic logic model_y(input int mode, input logic [3:0] xv);
        logic [3:0] kg;
        logic [3:0] kgb;
        logic [3:0] kg_n;
        kg   = m_key[3:0];
        kgb  = m_key[7:4];
        kg_n = ~kg;
        if (!m_loaded) return 1'b1;
        if (kg == kgb) return 1'b0;
        if (mode == 0) return (xv == kg_n);
        return (xv == kg);
    endfunction

    task automatic applyStimulus(input logic r, input logic [3:0] xv, input logic p,
                                 input logic kv, input logic kb, input logic kc);
        exp_t e;
        st_t  s;
        logic ya, yb;
        @(negedge clk);
        rst_n           = r;
        x_in            = xv;
        prot_in         = p;
        kif_a.key_valid = kv;
        kif_a.key_bit   = kb;
        kif_a.key_clear = kc;
        kif_b.key_valid = kv;
        kif_b.key_bit   = kb;
        kif_b.key_clear = kc;
        ya = model_y(0, xv);
        yb = model_y(1, xv);
        if (!r) begin
            for (int i = 0; i < q_a.size(); i++) begin
                e = q_a[i];
                if (e.due > cyc) begin e.prot = 1'b0; e.y = 1'b0; q_a[i] = e; end
            end
            for (int i = 0; i < q_b.size(); i++) begin
                e = q_b[i];
                if (e.due > cyc) begin e.prot = 1'b0; e.y = 1'b0; q_b[i] = e; end
            end
            q_a.push_back('{cyc + 1, 1'b0, 1'b0});
            q_b.push_back('{cyc + 3, 1'b0, 1'b0});
            m_key = '0; m_cnt = 0; m_loaded = 1'b0;
        end else begin
            q_a.push_back('{cyc + 1, p ^ ya, ya});
            q_b.push_back('{cyc + 3, p ^ yb, yb});
            if (kc) begin
                m_key = '0; m_cnt = 0; m_loaded = 1'b0;
            end else if (!m_loaded && kv) begin
                m_key[m_cnt] = kb;
                m_cnt++;
                if (m_cnt == 8) m_loaded = 1'b1;
            end
        end
        s.due    = cyc + 1;
        s.ready  = r && !m_loaded;
        s.loaded = r && m_loaded;
        q_s.push_back(s);
    endtask

    task automatic loadKey(input logic [7:0] k);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'(i), k[i], 1'b1, k[i], 1'b0);
    endtask

    task automatic checkOutput();
        exp_t e;
        st_t  s;
        while (q_a.size() > 0 && q_a[0].due <= cyc) begin
            e = q_a.pop_front();
            checks++;
            if ({prot_a, y_a} !== {e.prot, e.y}) begin
                errors++;
                $display("[TB] FAIL pipe_a cyc=%0d got prot_out=%b y_out=%b want prot_out=%b y_out=%b",
                         cyc, prot_a, y_a, e.prot, e.y);
            end
        end
        while (q_b.size() > 0 && q_b[0].due <= cyc) begin
            e = q_b.pop_front();
            checks++;
            if ({prot_b, y_b} !== {e.prot, e.y}) begin
                errors++;
                $display("[TB] FAIL pipe_b cyc=%0d got prot_out=%b y_out=%b want prot_out=%b y_out=%b",
                         cyc, prot_b, y_b, e.prot, e.y);
            end
        end
        while (q_s.size() > 0 && q_s[0].due <= cyc) begin
            s = q_s.pop_front();
            checks++;
            if ({kif_a.key_ready, kif_a.key_loaded, kif_b.key_ready, kif_b.key_loaded}
                !== {s.ready, s.loaded, s.ready, s.loaded}) begin
                errors++;
                $display("[TB] FAIL status cyc=%0d got a:rdy=%b ld=%b b:rdy=%b ld=%b want rdy=%b ld=%b",
                         cyc, kif_a.key_ready, kif_a.key_loaded, kif_b.key_ready, kif_b.key_loaded,
                         s.ready, s.loaded);
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        checkOutput();
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; x_in = '0; prot_in = 1'b0;
        kif_a.key_valid = 1'b0; kif_a.key_bit = 1'b0; kif_a.key_clear = 1'b0;
        kif_b.key_valid = 1'b0; kif_b.key_bit = 1'b0; kif_b.key_clear = 1'b0;

        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(i * 5), 1'b1, 1'b0, 1'b0, 1'b0);

        loadKey(8'b1010_1010);
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 4'(i), i[0], 1'b1, 1'($urandom_range(0, 1)), 1'b0);

        applyStimulus(1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i), i[1], 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        loadKey(8'b0001_0000);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        loadKey(8'b0111_0011);
        applyStimulus(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        loadKey(8'b0110_0110);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 9), i[0], 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 2), i[0], 1'b0, 1'b0, 1'b0);
        loadKey(8'b0110_0110);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i * 3), ~i[0], 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        checks++;
        if (q_a.size() + q_b.size() + q_s.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending want 0", q_a.size() + q_b.size() + q_s.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
